// File: rtl/sobel_window_gen.sv
// sobel_window_gen: streaming 3x3 neighbourhood generator feeding a Sobel stage.
// Pixels arrive in raster order over valid/ready. A shift line of 2*WIDTH+3
// pixels holds every neighbour that a pending interior window can still need.
// One window per pixel position leaves through a registered output stage.
// Border windows are zero and carry a flag.
module sobel_window_gen #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(WIDTH*DEPTH+1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_pixel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [71:0]              out_window,
    output logic                     out_border,
    output logic [$clog2(WIDTH)-1:0] out_x,
    output logic [$clog2(DEPTH)-1:0] out_y,
    output logic                     frame_done
);

    localparam int XW    = $clog2(WIDTH);
    localparam int YW    = $clog2(DEPTH);
    localparam int TOTAL = WIDTH * DEPTH;
    // Input may lead output by WIDTH+2 pixels. The oldest pixel a window uses
    // lies WIDTH+1 behind its centre, so 2*WIDTH+3 entries cover the live span.
    localparam int LEN   = 2 * WIDTH + 3;

    localparam logic [CW:0]   TOTAL_EXT = (CW+1)'(TOTAL);
    localparam logic [CW:0]   LEAD_EXT  = (CW+1)'(WIDTH + 2);
    localparam logic [CW-1:0] LAST_WIN  = CW'(TOTAL - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(DEPTH - 1);

    logic [CW-1:0] in_cnt_reg, in_cnt_next;
    logic [CW-1:0] out_cnt_reg, out_cnt_next;
    logic [XW-1:0] ox_reg, ox_next;
    logic [YW-1:0] oy_reg, oy_next;

    logic [7:0]    line_reg  [LEN];
    logic [7:0]    line_next [LEN];

    logic          out_valid_reg;
    logic [71:0]   out_window_reg;
    logic          out_border_reg;
    logic [XW-1:0] out_x_reg;
    logic [YW-1:0] out_y_reg;
    logic          frame_done_reg;

    logic          room_ok;
    logic          in_beat;
    logic          out_beat;
    logic          last_win;
    logic          border_next;
    logic          interior_ok;
    logic          emit_next;
    logic          load;
    logic [71:0]   win_next;

    // Input accepted while the frame is incomplete and the lead is below WIDTH+2.
    // Gating with rst_n keeps in_ready low for the whole reset interval.
    assign room_ok  = ({1'b0, in_cnt_reg} < TOTAL_EXT) &&
                      ({1'b0, in_cnt_reg} < ({1'b0, out_cnt_reg} + LEAD_EXT));
    assign in_ready = rst_n & room_ok;
    assign in_beat  = in_valid & in_ready;
    assign out_beat = out_valid_reg & out_ready;
    assign last_win = (out_cnt_reg == LAST_WIN);

    // Next counters and centre coordinates. The last output beat wraps the frame.
    always_comb begin
        in_cnt_next  = in_cnt_reg;
        out_cnt_next = out_cnt_reg;
        ox_next      = ox_reg;
        oy_next      = oy_reg;
        if (out_beat && last_win) begin
            // All pixels are already in at this point, so no input beat is lost.
            in_cnt_next  = '0;
            out_cnt_next = '0;
            ox_next      = '0;
            oy_next      = '0;
        end else begin
            if (in_beat) begin
                in_cnt_next = in_cnt_reg + CW'(1);
            end
            if (out_beat) begin
                out_cnt_next = out_cnt_reg + CW'(1);
                if (ox_reg == X_LAST) begin
                    ox_next = '0;
                    oy_next = oy_reg + YW'(1);
                end else begin
                    ox_next = ox_reg + XW'(1);
                end
            end
        end
    end

    // Post-edge view of the shift line: entry 0 is the newest pixel.
    genvar gi;
    generate
        for (gi = 0; gi < LEN; gi++) begin : g_line
            if (gi == 0) begin : g_head
                assign line_next[gi] = in_beat ? in_pixel : line_reg[gi];
            end else begin : g_body
                assign line_next[gi] = in_beat ? line_reg[gi-1] : line_reg[gi];
            end
        end
    endgenerate

    // An interior window is emittable only when the lead is exactly WIDTH+2.
    // Pixel (ox-1+c, oy-1+r) then sits at a fixed depth in the line.
    generate
        for (gi = 0; gi < 9; gi++) begin : g_tap
            localparam int TAP = 2*WIDTH + 2 - (gi / 3) * WIDTH - (gi % 3);
            assign win_next[8*gi +: 8] = line_next[TAP];
        end
    endgenerate

    assign border_next = (ox_next == '0) || (ox_next == X_LAST) ||
                         (oy_next == '0) || (oy_next == Y_LAST);
    assign interior_ok = ({1'b0, in_cnt_next} >= ({1'b0, out_cnt_next} + LEAD_EXT));
    assign emit_next   = border_next | interior_ok;
    assign load        = ~out_valid_reg | out_ready;

    // Frame counters and centre coordinates of the pending window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_reg  <= '0;
            out_cnt_reg <= '0;
            ox_reg      <= '0;
            oy_reg      <= '0;
        end else begin
            in_cnt_reg  <= in_cnt_next;
            out_cnt_reg <= out_cnt_next;
            ox_reg      <= ox_next;
            oy_reg      <= oy_next;
        end
    end

    // Pixel shift line; shifts only on accepted input beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LEN; i++) begin
                line_reg[i] <= '0;
            end
        end else if (in_beat) begin
            line_reg[0] <= in_pixel;
            for (int i = 1; i < LEN; i++) begin
                line_reg[i] <= line_reg[i-1];
            end
        end
    end

    // Registered output stage. It holds while stalled and reloads whenever the slot frees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_window_reg <= '0;
            out_border_reg <= 1'b0;
            out_x_reg      <= '0;
            out_y_reg      <= '0;
        end else if (load) begin
            out_valid_reg  <= emit_next;
            out_window_reg <= border_next ? 72'd0 : win_next;
            out_border_reg <= border_next;
            out_x_reg      <= ox_next;
            out_y_reg      <= oy_next;
        end
    end

    // One-cycle pulse after the last window of a frame is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= out_beat & last_win;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_window = out_window_reg;
    assign out_border = out_border_reg;
    assign out_x      = out_x_reg;
    assign out_y      = out_y_reg;
    assign frame_done = frame_done_reg;

endmodule
